// File: rtl/ether_tx_arbiter.sv
// ---------------------------------------------------------------------------
// ether_tx_arbiter
//
// Shares one RMII transmit interface between two payload sources. A source is
// chosen round-robin, the arbiter emits the preamble and SFD, streams the
// granted source's payload dibits, then holds the line idle for the
// inter-frame gap. Payloads that stall (underrun) or exceed MAX_DIBITS are
// truncated on the pins and the rest of the source frame is discarded.
//
// Ports:
//   clk, rst_n              RMII 50 MHz reference clock, async active-low reset
//   s0_valid/data/last      source 0 payload dibit stream (LSB dibit first)
//   s0_ready                source 0 dibit accepted this cycle (combinational)
//   s1_*                    same as source 0, for source 1
//   txen, txd               registered RMII transmit enable and dibit
//   grant                   one-hot current owner, 2'b00 when idle
//   busy                    high whenever the arbiter is not idle
//   frame_done              one-cycle pulse, frame completed normally
//   abort_err               one-cycle pulse, frame truncated on the pins
//
// Output timing: txen/txd are loaded with what the next state wants to show,
// so the state machine runs one cycle ahead of the pins. frame_done appears
// together with the last payload dibit; abort_err appears together with the
// first idle dibit of a truncated frame.
// PREAMBLE_DIBITS must be at least 1.
// ---------------------------------------------------------------------------
module ether_tx_arbiter #(
  parameter int PREAMBLE_DIBITS = 31,
  parameter int IFG_DIBITS      = 48,
  parameter int MAX_DIBITS      = 6072
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_valid,
  input  logic [1:0] s0_data,
  input  logic       s0_last,
  output logic       s0_ready,
  input  logic       s1_valid,
  input  logic [1:0] s1_data,
  input  logic       s1_last,
  output logic       s1_ready,
  output logic       txen,
  output logic [1:0] txd,
  output logic [1:0] grant,
  output logic       busy,
  output logic       frame_done,
  output logic       abort_err
);

  localparam int MAX_A   = (PREAMBLE_DIBITS > IFG_DIBITS) ? PREAMBLE_DIBITS : IFG_DIBITS;
  localparam int CNT_TOP = (MAX_A > MAX_DIBITS) ? MAX_A : MAX_DIBITS;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SFD,
    ST_PAYLOAD,
    ST_DRAIN,
    ST_IFG
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         grant_q, grant_d;
  logic               rr_next_q, rr_next_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               txen_q, txen_d;
  logic [1:0]         txd_q, txd_d;
  logic               frame_done_q, frame_done_d;
  logic               abort_err_q, abort_err_d;

  logic [1:0]         valid_vec;
  logic [1:0]         last_vec;
  logic [1:0]         ready_vec;
  logic               xfer_state;
  logic               sel_valid;
  logic               sel_last;
  logic [1:0]         sel_data;
  logic [CNT_W-1:0]   cnt_inc;

  assign valid_vec  = {s1_valid, s0_valid};
  assign last_vec   = {s1_last, s0_last};
  assign xfer_state = (state_q == ST_PAYLOAD) || (state_q == ST_DRAIN);

  // Only the owner ever sees ready, and only while payload is being moved
  // (streamed or drained).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ready
      assign ready_vec[gi] = grant_q[gi] & xfer_state;
    end
  endgenerate

  assign s0_ready = ready_vec[0];
  assign s1_ready = ready_vec[1];

  assign sel_valid = |(valid_vec & grant_q);
  assign sel_last  = |(last_vec & grant_q);
  assign sel_data  = grant_q[1] ? s1_data : s0_data;
  assign cnt_inc   = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      grant_q      <= 2'b00;
      rr_next_q    <= 1'b0;
      cnt_q        <= '0;
      txen_q       <= 1'b0;
      txd_q        <= 2'b00;
      frame_done_q <= 1'b0;
      abort_err_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      rr_next_q    <= rr_next_d;
      cnt_q        <= cnt_d;
      txen_q       <= txen_d;
      txd_q        <= txd_d;
      frame_done_q <= frame_done_d;
      abort_err_q  <= abort_err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    rr_next_d    = rr_next_q;
    cnt_d        = cnt_q;
    txen_d       = 1'b0;
    txd_d        = 2'b00;
    frame_done_d = 1'b0;
    abort_err_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (|valid_vec) begin
          if (&valid_vec) begin
            grant_d   = rr_next_q ? 2'b10 : 2'b01;
            rr_next_d = ~rr_next_q;
          end else if (s0_valid) begin
            grant_d   = 2'b01;
            rr_next_d = 1'b1;
          end else begin
            grant_d   = 2'b10;
            rr_next_d = 1'b0;
          end
          // The first preamble dibit is loaded on the grant edge so it is on
          // the pins one cycle after the grant cycle.
          cnt_d   = '0;
          txen_d  = 1'b1;
          txd_d   = 2'b01;
          state_d = (PREAMBLE_DIBITS > 1) ? ST_PREAMBLE : ST_SFD;
        end
      end

      ST_PREAMBLE: begin
        // cnt counts preamble dibits loaded after the first one.
        txen_d = 1'b1;
        txd_d  = 2'b01;
        cnt_d  = cnt_inc;
        if (cnt_inc == CNT_W'(PREAMBLE_DIBITS - 1)) begin
          state_d = ST_SFD;
        end
      end

      ST_SFD: begin
        txen_d  = 1'b1;
        txd_d   = 2'b11;
        cnt_d   = '0;
        state_d = ST_PAYLOAD;
      end

      ST_PAYLOAD: begin
        if (sel_valid) begin
          txen_d = 1'b1;
          txd_d  = sel_data;
          cnt_d  = cnt_inc;
          if (sel_last) begin
            // last wins over the size limit on the same transfer
            frame_done_d = 1'b1;
            cnt_d        = '0;
            state_d      = ST_IFG;
          end else if (cnt_inc == CNT_W'(MAX_DIBITS)) begin
            // Oversize: this dibit still goes out; the abort pulse is raised
            // from DRAIN so it lines up with txen falling.
            state_d = ST_DRAIN;
          end
        end else begin
          abort_err_d = 1'b1;
          state_d     = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        // txen_q is still high only on the first drain cycle after an
        // oversize truncation; underrun already pulsed and dropped txen.
        abort_err_d = txen_q;
        if (sel_valid && sel_last) begin
          cnt_d   = '0;
          state_d = ST_IFG;
        end
      end

      ST_IFG: begin
        // Gap is measured on the pins: cycles still showing the final
        // payload dibit do not count.
        if (!txen_q) begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(IFG_DIBITS)) begin
            cnt_d   = '0;
            grant_d = 2'b00;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        grant_d = 2'b00;
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign txen       = txen_q;
  assign txd        = txd_q;
  assign grant      = grant_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;
  assign abort_err  = abort_err_q;

endmodule

// File: tb/tb_ether_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ether_tx_arbiter
//
// Sources are queues of {hole, last, data} entries; a hole entry withholds
// valid for one cycle the first time the source is offered ready at it.
// The reference model works per frame: from the frame length, the hole
// position and the size limit it derives the dibits actually sent, the
// termination kind and the idle tail, then expands that into the expected
// per-cycle pin trace. Owners follow round-robin over the pending frames.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ether_tx_arbiter;

  localparam int PRE  = 31;
  localparam int IFG  = 48;
  localparam int MAXD = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       s0_valid = 1'b0, s0_last = 1'b0, s1_valid = 1'b0, s1_last = 1'b0;
  logic [1:0] s0_data = 2'b00, s1_data = 2'b00;
  logic       s0_ready, s1_ready, txen, busy, frame_done, abort_err;
  logic [1:0] txd, grant;

  ether_tx_arbiter #(
    .PREAMBLE_DIBITS(PRE),
    .IFG_DIBITS(IFG),
    .MAX_DIBITS(MAXD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .txen(txen), .txd(txd), .grant(grant), .busy(busy),
    .frame_done(frame_done), .abort_err(abort_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       txen;
    logic [1:0] txd;
    logic [1:0] grant;
    logic       busy;
    logic       done;
    logic       abort;
    logic [1:0] ready;
  } obs_t;

  typedef struct packed {
    int n;
    int hole;
  } frame_t;

  typedef struct {
    int port;
    int len;
    int hole;
    int exp_sent;
    int exp_done;
    int exp_abort;
    int exp_tail;
  } vec_t;

  obs_t       exp_q[$];
  logic [3:0] src0_q[$], src1_q[$];
  logic [1:0] mdat0_q[$], mdat1_q[$];
  frame_t     fr0_q[$], fr1_q[$];
  logic [1:0] owners_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int m_txen, m_done, m_abort, m_tail;
  logic prev_txen;

  function automatic obs_t sample();
    obs_t r;
    r.txen  = txen;
    r.txd   = txd;
    r.grant = grant;
    r.busy  = busy;
    r.done  = frame_done;
    r.abort = abort_err;
    r.ready = {s1_ready, s0_ready};
    return r;
  endfunction

  task automatic check_obs(input string name, input obs_t act, input obs_t expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %b want %b (txen,txd,grant,busy,done,abort,ready)",
               name, cyc, act, expv);
    end
  endtask

  task automatic check_int(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic drive();
    logic [3:0] e;
    if (src0_q.size() == 0) begin
      s0_valid = 1'b0; s0_data = 2'b00; s0_last = 1'b0;
    end else begin
      e = src0_q[0];
      if (e[3] && s0_ready) begin
        s0_valid = 1'b0; e[3] = 1'b0; src0_q[0] = e;
      end else begin
        s0_valid = 1'b1; s0_data = e[1:0]; s0_last = e[2];
        if (s0_ready) void'(src0_q.pop_front());
      end
    end
    if (src1_q.size() == 0) begin
      s1_valid = 1'b0; s1_data = 2'b00; s1_last = 1'b0;
    end else begin
      e = src1_q[0];
      if (e[3] && s1_ready) begin
        s1_valid = 1'b0; e[3] = 1'b0; src1_q[0] = e;
      end else begin
        s1_valid = 1'b1; s1_data = e[1:0]; s1_last = e[2];
        if (s1_ready) void'(src1_q.pop_front());
      end
    end
  endtask

  // Called just after each falling edge: observe this cycle, then set up the
  // inputs the next rising edge will sample.
  task automatic step();
    obs_t a;
    obs_t e;
    a = sample();
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_obs("trace", a, e);
    end
    if (a.txen && !prev_txen) owners_q.push_back(a.grant);
    if (a.txen) m_txen++;
    if (a.done) m_done++;
    if (a.abort) m_abort++;
    if (a.busy && !a.txen && m_txen > 0) m_tail++;
    prev_txen = a.txen;
    drive();
    cyc++;
  endtask

  task automatic add_frame(input int p, input int n, input int hole);
    logic [1:0] d;
    frame_t f;
    for (int i = 0; i < n; i++) begin
      d = 2'($urandom_range(0, 3));
      if (p == 0) begin
        src0_q.push_back({(hole == i), (i == n - 1), d});
        mdat0_q.push_back(d);
      end else begin
        src1_q.push_back({(hole == i), (i == n - 1), d});
        mdat1_q.push_back(d);
      end
    end
    f.n = n;
    f.hole = hole;
    if (p == 0) fr0_q.push_back(f); else fr1_q.push_back(f);
  endtask

  task automatic build_model();
    int rr;
    int p, lim, sent, tail, rlen, total;
    bit ab, has_hole;
    frame_t f;
    logic [1:0] own;
    logic [1:0] d[$];
    obs_t r;
    rr = 0;
    while (fr0_q.size() + fr1_q.size() > 0) begin
      if (fr0_q.size() > 0 && fr1_q.size() > 0) p = rr;
      else if (fr0_q.size() > 0) p = 0;
      else p = 1;
      rr = 1 - p;
      if (p == 0) f = fr0_q.pop_front(); else f = fr1_q.pop_front();
      d.delete();
      for (int i = 0; i < f.n; i++)
        d.push_back((p == 0) ? mdat0_q.pop_front() : mdat1_q.pop_front());
      lim      = (f.n < MAXD) ? f.n : MAXD;
      has_hole = (f.hole >= 0) && (f.hole < f.n);
      if (f.hole >= 0 && f.hole < lim) begin
        sent = f.hole; ab = 1'b1; tail = f.n - f.hole + IFG;
      end else if (f.n <= MAXD) begin
        sent = f.n; ab = 1'b0; tail = IFG;
      end else begin
        sent = MAXD; ab = 1'b1; tail = f.n - MAXD - 1 + IFG + (has_hole ? 1 : 0);
      end
      // every source dibit takes one ready cycle, plus one for the stalled cycle
      rlen  = f.n + (has_hole ? 1 : 0);
      own   = (p == 0) ? 2'b01 : 2'b10;
      total = 1 + PRE + 1 + sent + tail;
      for (int k = 0; k < total; k++) begin
        r = '0;
        if (k >= 1) begin r.busy = 1'b1; r.grant = own; end
        if (k >= 1 && k <= PRE) begin
          r.txen = 1'b1; r.txd = 2'b01;
        end else if (k == PRE + 1) begin
          r.txen = 1'b1; r.txd = 2'b11;
        end else if (k >= PRE + 2 && k < PRE + 2 + sent) begin
          r.txen = 1'b1; r.txd = d[k - PRE - 2];
        end
        if (!ab && k == PRE + 1 + sent) r.done = 1'b1;
        if (ab && k == PRE + 2 + sent) r.abort = 1'b1;
        if (k >= PRE + 1 && k < PRE + 1 + rlen) r.ready = own;
        exp_q.push_back(r);
      end
    end
    for (int k = 0; k < 3; k++) exp_q.push_back(obs_t'(0));
  endtask

  task automatic clear_meas();
    m_txen = 0; m_done = 0; m_abort = 0; m_tail = 0;
    prev_txen = 1'b0;
    owners_q.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    src0_q.delete(); src1_q.delete();
    mdat0_q.delete(); mdat1_q.delete();
    fr0_q.delete(); fr1_q.delete();
    exp_q.delete();
    drive();
    repeat (3) @(negedge clk);
    check_obs("reset", sample(), obs_t'(0));
  endtask

  // Release reset and run until the expected trace is exhausted.
  task automatic run_scenario();
    build_model();
    clear_meas();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    while (exp_q.size() > 0) begin
      @(negedge clk);
      step();
    end
  endtask

  vec_t vecs[8];

  initial begin
    //          port len hole sent done abort tail
    vecs[0] = '{0,   8,  -1,  8,   1,   0,   48};
    vecs[1] = '{1,  10,   5,  5,   0,   1,   53};
    vecs[2] = '{0,  20,  -1, 16,   0,   1,   51};
    vecs[3] = '{0,  16,  -1, 16,   1,   0,   48};
    vecs[4] = '{1,   1,  -1,  1,   1,   0,   48};
    vecs[5] = '{0,  17,  16, 16,   0,   1,   49};
    vecs[6] = '{1,   3,   0,  0,   0,   1,   51};
    vecs[7] = '{1,  16,  15, 15,   0,   1,   49};

    // Single-frame vectors
    for (int v = 0; v < 8; v++) begin
      do_reset();
      add_frame(vecs[v].port, vecs[v].len, vecs[v].hole);
      run_scenario();
      check_int($sformatf("v%0d_sent", v), m_txen - PRE - 1, vecs[v].exp_sent);
      check_int($sformatf("v%0d_done", v), m_done, vecs[v].exp_done);
      check_int($sformatf("v%0d_abort", v), m_abort, vecs[v].exp_abort);
      check_int($sformatf("v%0d_tail", v), m_tail, vecs[v].exp_tail);
      $display("vector %0d: port=%0d len=%0d hole=%0d sent=%0d done=%0d abort=%0d tail=%0d",
               v, vecs[v].port, vecs[v].len, vecs[v].hole, m_txen - PRE - 1,
               m_done, m_abort, m_tail);
    end

    // Strict alternation with both sources always requesting
    do_reset();
    add_frame(0, 4, -1); add_frame(0, 4, -1);
    add_frame(1, 4, -1); add_frame(1, 4, -1);
    run_scenario();
    check_int("alt_count", owners_q.size(), 4);
    for (int i = 0; i < 4 && i < owners_q.size(); i++) begin
      check_int($sformatf("alt_owner%0d", i), int'(owners_q[i]), (i % 2 == 0) ? 1 : 2);
      $display("alternation frame %0d: grant=%b", i, owners_q[i]);
    end

    // Asynchronous reset in the middle of an s0 payload with s1 waiting
    do_reset();
    add_frame(0, 12, -1);
    add_frame(1, 6, -1);
    build_model();
    clear_meas();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 39; i++) begin
      @(negedge clk);
      step();
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_obs("async_reset", sample(), obs_t'(0));
    $display("mid-payload reset: txen=%b txd=%b grant=%b busy=%b ready=%b",
             txen, txd, grant, busy, {s1_ready, s0_ready});
    src0_q.delete(); src1_q.delete(); exp_q.delete();
    add_frame(1, 6, -1);
    drive();
    repeat (2) @(negedge clk);
    run_scenario();
    check_int("reset_s1_owner", (owners_q.size() > 0) ? int'(owners_q[0]) : 0, 2);
    check_int("reset_s1_done", m_done, 1);

    // Randomized traffic against the frame-level model
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int p = 0; p < 2; p++) begin
        for (int i = 0; i < 5; i++) begin
          int n;
          int h;
          n = $urandom_range(1, 22);
          h = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
          add_frame(p, n, h);
        end
      end
      run_scenario();
      $display("random round %0d: frames=%0d done=%0d abort=%0d cycles=%0d",
               round, owners_q.size(), m_done, m_abort, cyc);
      check_int($sformatf("rand%0d_frames", round), m_done + m_abort, 10);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ether_tx_arbiter.md
Name: ether_tx_arbiter

Overview:
- Shares one RMII transmit interface (txen/txd dibits, 50 MHz ref clock) between two frame sources.
- Each source presents a payload dibit stream: destination MAC through FCS, LSB dibit first.
- Picks a source round-robin, prepends the preamble and SFD, streams the payload, then enforces the inter-frame gap.
- Acts as the transmit-side counterpart of the receive preamble stripper; sits between the packet builders and the PHY pins.

Parameters:
- PREAMBLE_DIBITS, 31: count of 2'b01 dibits sent before the SFD.
- IFG_DIBITS, 48: idle dibits (txen=0) after every frame or abort; 96 bit times.
- MAX_DIBITS, 6072: maximum payload dibits per frame (1518 bytes); 13-bit counter.

Ports:
- clk  in  1  RMII reference clock, 50 MHz.
- rst_n  in  1  asynchronous active-low reset.
- s0_valid  in  1  source 0 has a dibit.
- s0_data  in  2  source 0 payload dibit.
- s0_last  in  1  marks the final dibit of the source 0 frame.
- s0_ready  out  1  source 0 dibit accepted this cycle.
- s1_valid, s1_data[1:0], s1_last, s1_ready: same as source 0, for source 1.
- txen  out  1  RMII TX enable, registered.
- txd  out  2  RMII TX dibit, registered.
- grant  out  2  one-hot current owner; 2'b00 when idle.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after a frame completes normally.
- abort_err  out  1  one-cycle pulse when a frame is truncated (underrun or oversize).

Behaviour:
- Reset: while rst_n=0, all outputs are 0, state=IDLE, rr_next=0, counters=0. Reset takes effect immediately (asynchronous), including mid-frame; txen drops without completing the frame.
- States: IDLE, PREAMBLE, SFD, PAYLOAD, DRAIN, IFG.
- IDLE:
  - If either s*_valid is high, grant the requester.
  - If both are high, grant rr_next; rr_next then flips to the other port.
  - If only one is high, grant it; rr_next is set to the other port.
  - Register grant, clear the counter, go to PREAMBLE. txen=0.
- PREAMBLE: drive txen=1, txd=2'b01 for PREAMBLE_DIBITS cycles, then go to SFD.
- SFD: one cycle with txen=1, txd=2'b11, then go to PAYLOAD.
- Output timing: txen and txd are registered. The first preamble dibit appears on the pins 1 cycle after the grant cycle. Grant-to-first-payload-dibit on pins is PREAMBLE_DIBITS+2 cycles.
- s*_ready:
  - Combinational; equal to grant[i] when state is PAYLOAD or DRAIN, 0 otherwise.
  - The non-granted port never sees ready.
- PAYLOAD:
  - On valid&&ready: txd<=data, txen<=1 next cycle, payload counter +1.
  - If last is set on that transfer: go to IFG and pulse frame_done.
  - Underrun: granted valid=0 in any PAYLOAD cycle. Then txen<=0 next cycle, pulse abort_err, go to DRAIN.
  - Oversize: counter reaches MAX_DIBITS with no last seen. The MAX_DIBITS-th dibit is still sent; then txen<=0, pulse abort_err, go to DRAIN.
  - If the oversize limit and last coincide on the same transfer, the frame completes normally (frame_done, no abort_err).
- DRAIN:
  - txen=0. Ready stays asserted to the owner, and dibits are discarded until a transfer with last=1.
  - Then go to IFG. No second abort_err pulse.
- IFG:
  - txen=0, txd=2'b00 for IFG_DIBITS cycles.
  - The count starts on the first cycle in which the pins show txen=0.
  - Then grant<=0 and go to IDLE. A new grant is possible in that IDLE cycle.
- txd=2'b00 whenever txen=0.
- A request arriving while busy waits; its valid must stay high. The arbiter never preempts.
- frame_done and abort_err are never high in the same cycle.

Test Plan:
- Single frame from s0, 8 dibits, last on the 8th:
  - Pins show 31×01, 1×11, then the 8 dibits in order with txen=1.
  - Then 48 cycles of txen=0; frame_done pulses once; grant returns to 00.
- Both sources valid in the same IDLE cycle after reset:
  - s0 is served first, then s1 after the IFG.
  - Repeat with both valid: s0 again.
  - Checks strict alternation: s0, s1, s0, s1.
- s1 drops valid for 1 cycle after its 5th dibit:
  - txen falls on the following cycle; abort_err pulses.
  - Remaining s1 dibits are consumed with txen=0 until last; 48-cycle IFG follows.
- MAX_DIBITS=16, s0 sends 20 dibits, last on the 20th:
  - Exactly 16 payload dibits appear on txd; abort_err pulses.
  - Dibits 17–20 are drained; IFG follows.
- MAX_DIBITS=16, last on dibit 16: normal completion, frame_done pulses, no abort_err.
- Assert rst_n=0 during PAYLOAD:
  - txen, txd, grant, busy, s*_ready all 0 in the same cycle.
  - After release, a pending s1 request receives a full preamble from the first dibit.
